// File: rtl/y86_seq_ctrl.sv
// Multi-cycle sequencer for the SEQ Y86-64 core: owns the PC, walks each
// instruction through F/D/E/M/W/PC-update and tracks the architectural status.
module y86_seq_ctrl #(
    parameter logic [63:0] RESET_PC    = 64'd0,
    parameter int          MEM_TIMEOUT = 16,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             inst_valid,
    input  logic             imem_er,
    input  logic             hlt_er,
    input  logic [63:0]      valC,
    input  logic [63:0]      valP,
    input  logic             cnd,
    input  logic [63:0]      valM,
    input  logic             dmem_ready,
    input  logic             dmem_er,
    output logic [63:0]      pc,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic [2:0]       stat,
    output logic             halted,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_PCUPD, S_HALT
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state;
    logic [3:0]  icode_q;
    logic        cnd_q;
    logic [63:0] valC_q;
    logic [63:0] valP_q;
    logic [63:0] valM_q;
    logic [7:0]  wait_cnt;
    logic        mem_op;
    logic [63:0] next_pc;

    // Data-memory handshake: mem_en is held as a request while in MEM for a
    // memory icode; the access completes on the first cycle dmem_ready=1, and
    // dmem_er is only meaningful in that same cycle.
    always_comb begin
        mem_op = 1'b0;
        case (icode_q)
            4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11: mem_op = 1'b1;
            default:                              mem_op = 1'b0;
        endcase
    end

    always_comb begin
        next_pc = valP_q;
        if (icode_q == 4'd8 || (icode_q == 4'd7 && cnd_q))
            next_pc = valC_q;
        else if (icode_q == 4'd9)
            next_pc = valM_q;
    end

    // Outputs depend on registered state only, so reset takes effect at once.
    assign fetch_en  = (state == S_FETCH);
    assign decode_en = (state == S_DECODE);
    assign exec_en   = (state == S_EXEC);
    assign mem_en    = (state == S_MEM) && mem_op;
    assign wb_en     = (state == S_WB);
    assign halted    = (state == S_HALT);
    assign busy      = (state != S_IDLE) && (state != S_HALT);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            stat        <= STAT_AOK;
            icode_q     <= 4'd0;
            cnd_q       <= 1'b0;
            valC_q      <= 64'd0;
            valP_q      <= 64'd0;
            valM_q      <= 64'd0;
            wait_cnt    <= 8'd0;
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            if (busy && cycle_cnt != {CNT_W{1'b1}})
                cycle_cnt <= cycle_cnt + 1'b1;
            case (state)
                S_IDLE: if (start) state <= S_FETCH;
                S_FETCH: begin
                    if (imem_er) begin
                        stat  <= STAT_ADR;
                        state <= S_HALT;
                    end else if (!inst_valid) begin
                        stat  <= STAT_INS;
                        state <= S_HALT;
                    end else if (hlt_er) begin
                        stat  <= STAT_HLT;
                        state <= S_HALT;
                    end else begin
                        icode_q <= icode;
                        valC_q  <= valC;
                        valP_q  <= valP;
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: state <= S_EXEC;
                S_EXEC: begin
                    cnd_q    <= cnd;
                    wait_cnt <= 8'd0;
                    state    <= S_MEM;
                end
                S_MEM: begin
                    if (!mem_op) begin
                        state <= S_WB;
                    end else if (dmem_ready) begin
                        if (dmem_er) begin
                            stat  <= STAT_ADR;
                            state <= S_HALT;
                        end else begin
                            valM_q <= valM;
                            state  <= S_WB;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        stat  <= STAT_ADR;
                        state <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_WB: state <= S_PCUPD;
                S_PCUPD: begin
                    pc          <= next_pc;
                    retired_cnt <= retired_cnt + 1'b1;
                    state       <= S_FETCH;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Directed bench for y86_seq_ctrl: hand-computed PC, status, enable and
// counter expectations for plain, branch, memory, fault and reset cases.
module tb_y86_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  icode;
    logic        inst_valid;
    logic        imem_er;
    logic        hlt_er;
    logic [63:0] valC;
    logic [63:0] valP;
    logic        cnd;
    logic [63:0] valM;
    logic        dmem_ready;
    logic        dmem_er;
    logic [63:0] pc;
    logic        fetch_en, decode_en, exec_en, mem_en, wb_en;
    logic [2:0]  stat;
    logic        halted;
    logic        busy;
    logic [31:0] cycle_cnt;
    logic [31:0] retired_cnt;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    y86_seq_ctrl #(.RESET_PC(64'd0), .MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .icode(icode),
        .inst_valid(inst_valid), .imem_er(imem_er), .hlt_er(hlt_er),
        .valC(valC), .valP(valP), .cnd(cnd), .valM(valM),
        .dmem_ready(dmem_ready), .dmem_er(dmem_er), .pc(pc),
        .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
        .mem_en(mem_en), .wb_en(wb_en), .stat(stat), .halted(halted),
        .busy(busy), .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Sets fetch-side inputs for a clean instruction.
    task automatic drive_inst(input logic [3:0] ic, input logic [63:0] c, input logic [63:0] p);
        icode = ic; valC = c; valP = p;
        inst_valid = 1'b1; imem_er = 1'b0; hlt_er = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    function automatic logic [4:0] ens();
        return {fetch_en, decode_en, exec_en, mem_en, wb_en};
    endfunction

    logic [4:0]  exp_en [6];
    logic [31:0] cc0;
    int          n;

    initial begin
        rst = 1'b1; start = 1'b0; icode = 4'd0; inst_valid = 1'b0;
        imem_er = 1'b0; hlt_er = 1'b0; valC = 64'd0; valP = 64'd0;
        cnd = 1'b0; valM = 64'd0; dmem_ready = 1'b0; dmem_er = 1'b0;
        exp_en[0] = 5'b10000; exp_en[1] = 5'b01000; exp_en[2] = 5'b00100;
        exp_en[3] = 5'b00000; exp_en[4] = 5'b00001; exp_en[5] = 5'b00000;

        repeat (2) step();
        check("reset_pc", pc, 64'd0);
        check("reset_stat", 64'(stat), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_halted", 64'(halted), 64'd0);
        check("reset_en", 64'(ens()), 64'd0);
        check("reset_cycle", 64'(cycle_cnt), 64'd0);
        check("reset_retired", 64'(retired_cnt), 64'd0);
        rst = 1'b0;
        step();
        check("idle_busy", 64'(busy), 64'd0);

        // Plain instruction: one enable per cycle, mem_en never raised
        drive_inst(4'd3, 64'd0, 64'd10);
        start_run();
        for (int i = 0; i < 6; i++) begin
            check($sformatf("seq_en_%0d", i), 64'(ens()), 64'(exp_en[i]));
            step();
        end
        check("plain_pc", pc, 64'd10);
        check("plain_retired", 64'(retired_cnt), 64'd1);
        check("plain_stat", 64'(stat), 64'd1);
        check("plain_cycles", 64'(cycle_cnt), 64'd6);
        check("plain_fetch_again", 64'(fetch_en), 64'd1);

        // Conditional jump taken / not taken, unconditional call
        drive_inst(4'd7, 64'h40, 64'd9); cnd = 1'b1;
        repeat (6) step();
        check("jxx_taken", pc, 64'h40);
        drive_inst(4'd7, 64'h40, 64'd9); cnd = 1'b0;
        repeat (6) step();
        check("jxx_not_taken", pc, 64'd9);
        drive_inst(4'd8, 64'h40, 64'd9); cnd = 1'b0;
        dmem_ready = 1'b1;
        repeat (6) step();
        dmem_ready = 1'b0;
        check("call_pc", pc, 64'h40);
        // cnd changing after EXEC must be ignored
        drive_inst(4'd7, 64'h80, 64'h48); cnd = 1'b0;
        repeat (3) step();
        cnd = 1'b1;
        repeat (3) step();
        check("cnd_late_ignored", pc, 64'h48);
        cnd = 1'b0;

        // ret with dmem_ready on the third MEM cycle
        drive_inst(4'd9, 64'd0, 64'h49); valM = 64'h100;
        cc0 = cycle_cnt;
        repeat (3) step();
        n = 0;
        for (int i = 0; i < 3; i++) begin
            if (mem_en) n++;
            if (i == 2) dmem_ready = 1'b1;
            step();
        end
        dmem_ready = 1'b0;
        check("ret_mem_cycles", 64'(n), 64'd3);
        check("ret_wb_en", 64'(wb_en), 64'd1);
        check("ret_mem_en_off", 64'(mem_en), 64'd0);
        repeat (2) step();
        check("ret_pc", pc, 64'h100);
        check("ret_latency", 64'(cycle_cnt - cc0), 64'd8);
        check("ret_retired", 64'(retired_cnt), 64'd6);

        // mrmovq with dmem_ready held low: timeout after 16 MEM cycles
        drive_inst(4'd5, 64'd0, 64'h10a);
        repeat (3) step();
        n = 0;
        while (mem_en && n < 40) begin
            step();
            n++;
        end
        check("timeout_cycles", 64'(n), 64'd16);
        check("timeout_stat", 64'(stat), 64'd3);
        check("timeout_halted", 64'(halted), 64'd1);
        check("timeout_pc", pc, 64'h100);
        check("timeout_retired", 64'(retired_cnt), 64'd6);

        // Data-memory error on the first access cycle
        do_reset();
        drive_inst(4'd3, 64'd0, 64'h20);
        start_run();
        repeat (6) step();
        drive_inst(4'd4, 64'd0, 64'h2a);
        dmem_ready = 1'b1; dmem_er = 1'b1;
        repeat (4) step();
        dmem_ready = 1'b0; dmem_er = 1'b0;
        check("dmem_er_stat", 64'(stat), 64'd3);
        check("dmem_er_halted", 64'(halted), 64'd1);
        check("dmem_er_pc", pc, 64'h20);
        check("dmem_er_retired", 64'(retired_cnt), 64'd1);

        // Fetch fault priority
        do_reset();
        icode = 4'd3; imem_er = 1'b1; inst_valid = 1'b0; hlt_er = 1'b1;
        start_run();
        step();
        check("imem_er_prio", 64'(stat), 64'd3);
        do_reset();
        icode = 4'd3; imem_er = 1'b0; inst_valid = 1'b0; hlt_er = 1'b1;
        start_run();
        step();
        check("ins_stat", 64'(stat), 64'd4);
        check("ins_halted", 64'(halted), 64'd1);

        // Halt at 0x34, then start pulses must not wake it
        do_reset();
        drive_inst(4'd3, 64'd0, 64'h34);
        start_run();
        repeat (6) step();
        hlt_er = 1'b1;
        step();
        hlt_er = 1'b0;
        cc0 = cycle_cnt;
        check("hlt_stat", 64'(stat), 64'd2);
        check("hlt_halted", 64'(halted), 64'd1);
        check("hlt_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; step(); start = 1'b0; step();
        end
        check("hlt_pc_frozen", pc, 64'h34);
        check("hlt_still_halted", 64'(halted), 64'd1);
        check("hlt_cycle_frozen", 64'(cycle_cnt), 64'(cc0));

        // Asynchronous reset in the middle of EXEC
        do_reset();
        drive_inst(4'd3, 64'd0, 64'h50);
        start_run();
        repeat (6) step();
        drive_inst(4'd3, 64'd0, 64'h58);
        repeat (2) step();
        check("pre_rst_exec", 64'(exec_en), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pc", pc, 64'd0);
        check("async_rst_en", 64'(ens()), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_cycle", 64'(cycle_cnt), 64'd0);
        check("async_rst_retired", 64'(retired_cnt), 64'd0);
        check("async_rst_stat", 64'(stat), 64'd1);
        step();
        rst = 1'b0;
        drive_inst(4'd3, 64'd0, 64'd8);
        start_run();
        check("refetch_pc", pc, 64'd0);
        check("refetch_fetch_en", 64'(fetch_en), 64'd1);
        repeat (6) step();
        check("refetch_next_pc", pc, 64'd8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
